// File: rtl/multu_sequencer_pkg.sv
// rtl/multu_sequencer_pkg.sv - shared types and constants for the MULTU sequencer
package multu_sequencer_pkg;

   // Default operand width; HI and LO are each this wide
   localparam int WIDTH_DEF = 32;

   // R-type funct codes decoded by the ALU control unit to drive start/hilo_rd
   localparam logic [5:0] FUNCT_MULTU = 6'd25;
   localparam logic [5:0] FUNCT_MFHI  = 6'd16;
   localparam logic [5:0] FUNCT_MFLO  = 6'd18;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/multu_sequencer.sv
// rtl/multu_sequencer.sv - iterative shift-add unsigned multiplier with HI/LO and pipeline stall
module multu_sequencer
   import multu_sequencer_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             hilo_rd,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic             stall,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int             CW   = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   // Accumulator: upper WIDTH+1 bits hold the partial product plus its carry,
   // lower WIDTH bits start as the multiplier and shift out one bit per cycle
   logic [2*WIDTH:0]   acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   logic [WIDTH:0]     add_in;
   logic [WIDTH:0]     sum;
   logic               accept;

   // State and datapath registers; reset aborts any multiply in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         mcand_q <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // Next-state and datapath: accept in IDLE/DONE, one add-and-shift step per RUN cycle
   always_comb begin
      state_d = state_q;
      mcand_d = mcand_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;

      add_in  = acc_q[0] ? {1'b0, mcand_q} : '0;
      sum     = acc_q[2*WIDTH:WIDTH] + add_in;
      accept  = (state_q != ST_RUN) && start && !flush;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (accept) begin
               mcand_d = op_a;
               acc_d   = {1'b0, {WIDTH{1'b0}}, op_b};
               cnt_d   = '0;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (flush) begin
               // Cancelled: HI/LO keep their previous contents, no done pulse
               state_d = ST_IDLE;
            end else begin
               acc_d = {1'b0, sum, acc_q[WIDTH-1:1]};
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  hi_d    = acc_d[2*WIDTH-1:WIDTH];
                  lo_d    = acc_d[WIDTH-1:0];
                  state_d = ST_DONE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy  = (state_q == ST_RUN);
   assign done  = (state_q == ST_DONE);
   // Only a dependent instruction (another MULTU or MFHI/MFLO) needs holding
   assign stall = busy && (start || hilo_rd);
   assign hi    = hi_q;
   assign lo    = lo_q;

endmodule

// File: tb/tb_multu_sequencer.sv
// tb/tb_multu_sequencer.sv - directed self-checking bench for multu_sequencer
module tb_multu_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        hilo_rd;
   logic        flush;
   logic        busy;
   logic        done;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_cmp  = 0;
   int n_fail = 0;

   multu_sequencer #(.WIDTH(32)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .op_a    (op_a),
      .op_b    (op_b),
      .hilo_rd (hilo_rd),
      .flush   (flush),
      .busy    (busy),
      .done    (done),
      .stall   (stall),
      .hi      (hi),
      .lo      (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one multiply, then wait (bounded) until the done cycle
   task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                         output int busy_cnt, output bit got_done);
      op_a  = a;
      op_b  = b;
      start = 1'b1;
      step();
      start = 1'b0;
      busy_cnt = 0;
      got_done = 1'b0;
      for (int i = 0; i < 40 && !got_done; i++) begin
         if (done) got_done = 1'b1;
         else begin
            if (busy) busy_cnt++;
            step();
         end
      end
   endtask

   initial begin
      int  bc;
      bit  gd;
      int  stall_cnt;
      int  busy_err;
      int  done_seen;

      vecs[0] = '{32'd3,        32'd5,        32'h0000_0000, 32'h0000_000F};
      vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[2] = '{32'h8000_0000, 32'd2,        32'h0000_0001, 32'h0000_0000};
      vecs[3] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
      vecs[4] = '{32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE};
      vecs[5] = '{32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
      vecs[6] = '{32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_0000, 32'hFFFE_0001};
      vecs[7] = '{32'hDEAD_BEEF, 32'd0,        32'h0000_0000, 32'h0000_0000};

      rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; hilo_rd = 1'b0; flush = 1'b0;
      #12;
      chk("reset_busy",  {63'd0, busy},  64'd0);
      chk("reset_done",  {63'd0, done},  64'd0);
      chk("reset_stall", {63'd0, stall}, 64'd0);
      chk("reset_hilo",  {hi, lo},       64'd0);
      step();
      rst_n = 1'b1;
      step();

      // Table of products
      for (int v = 0; v < 8; v++) begin
         do_mul(vecs[v].a, vecs[v].b, bc, gd);
         chk($sformatf("vec%0d_done", v), {63'd0, gd}, 64'd1);
         chk($sformatf("vec%0d_busy_cycles", v), 64'(bc), 64'd32);
         chk($sformatf("vec%0d_hi", v), {32'd0, hi}, {32'd0, vecs[v].exp_hi});
         chk($sformatf("vec%0d_lo", v), {32'd0, lo}, {32'd0, vecs[v].exp_lo});
         step();
         chk($sformatf("vec%0d_idle_after_done", v), {62'd0, busy, done}, 64'd0);
      end

      // MFHI/MFLO dependency stalls from RUN cycle 5 to the last RUN cycle
      op_a = 32'h8000_0000; op_b = 32'd2; start = 1'b1;
      step();
      start = 1'b0;
      stall_cnt = 0; busy_err = 0;
      for (int c = 0; c < 32; c++) begin
         hilo_rd = (c >= 5);
         #1;
         if (stall) stall_cnt++;
         if (!busy) busy_err++;
         step();
      end
      chk("hilo_stall_cycles", 64'(stall_cnt), 64'd27);
      chk("hilo_busy_run", 64'(busy_err), 64'd0);
      chk("hilo_done", {63'd0, done}, 64'd1);
      chk("hilo_no_stall_in_done", {63'd0, stall}, 64'd0);
      chk("hilo_result", {hi, lo}, {32'd1, 32'd0});
      hilo_rd = 1'b0;
      step();

      // Flush mid-RUN, with an ignored start issued during RUN
      op_a = 32'd7; op_b = 32'd9; start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (c == 3) begin
            start = 1'b1; op_a = 32'd100; op_b = 32'd100;
            #1;
            chk("run_start_stalls", {63'd0, stall}, 64'd1);
         end else start = 1'b0;
         step();
      end
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_idle", {62'd0, busy, done}, 64'd0);
      chk("flush_hilo_kept", {hi, lo}, {32'd1, 32'd0});
      done_seen = 0;
      for (int c = 0; c < 40; c++) begin
         if (done || busy) done_seen++;
         step();
      end
      chk("flush_no_done_no_restart", 64'(done_seen), 64'd0);

      // Back-to-back: second start held into the DONE cycle of the first
      do_mul(32'd6, 32'd7, bc, gd);
      chk("b2b_first_done", {63'd0, gd}, 64'd1);
      chk("b2b_first_lo", {hi, lo}, {32'd0, 32'd42});
      op_a = 32'd2; op_b = 32'd4; start = 1'b1;
      #1;
      chk("b2b_done_no_stall", {63'd0, stall}, 64'd0);
      step();
      start = 1'b0;
      chk("b2b_second_running", {62'd0, busy, done}, 64'd2);
      bc = 0; gd = 1'b0;
      for (int i = 0; i < 40 && !gd; i++) begin
         if (done) gd = 1'b1;
         else begin
            if (busy) bc++;
            step();
         end
      end
      chk("b2b_second_busy", 64'(bc), 64'd32);
      chk("b2b_second_result", {hi, lo}, {32'd0, 32'd8});

      // Flush in DONE blocks the same-cycle start but the done pulse remains
      start = 1'b1; flush = 1'b1; op_a = 32'd5; op_b = 32'd5;
      #1;
      chk("done_flush_pulse", {63'd0, done}, 64'd1);
      step();
      start = 1'b0; flush = 1'b0;
      chk("done_flush_blocks_start", {62'd0, busy, done}, 64'd0);
      step();

      // Asynchronous reset mid-RUN
      op_a = 32'd11; op_b = 32'd13; start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 0; c < 10; c++) step();
      hilo_rd = 1'b1;
      #1;
      chk("pre_reset_stall", {63'd0, stall}, 64'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_reset_flags", {61'd0, busy, done, stall}, 64'd0);
      chk("async_reset_hilo", {hi, lo}, 64'd0);
      hilo_rd = 1'b0;
      step();
      rst_n = 1'b1;
      done_seen = 0;
      for (int c = 0; c < 40; c++) begin
         if (done || busy) done_seen++;
         step();
      end
      chk("reset_no_done", 64'(done_seen), 64'd0);

      // First multiply after reset behaves normally
      do_mul(32'd3, 32'd5, bc, gd);
      chk("post_reset_done", {63'd0, gd}, 64'd1);
      chk("post_reset_busy", 64'(bc), 64'd32);
      chk("post_reset_result", {hi, lo}, {32'd0, 32'd15});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/multu_sequencer.md
MULTU_SEQUENCER -- requirements
Module: multu_sequencer

Interface
REQ-001 Parameter: WIDTH, 32, operand width; HI and LO are each WIDTH bits.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  MULTU issued from ID/EX; sampled only when accept condition holds.
REQ-005 op_a  input  WIDTH  multiplicand (rs), unsigned.
REQ-006 op_b  input  WIDTH  multiplier (rt), unsigned.
REQ-007 hilo_rd  input  1  MFHI/MFLO in ID/EX needs HI/LO this cycle.
REQ-008 flush  input  1  pipeline flush; cancels an in-flight multiply.
REQ-009 busy  output  1  multiply in progress.
REQ-010 done  output  1  one-cycle pulse, HI/LO just updated.
REQ-011 stall  output  1  hold IF/ID/EX stages.
REQ-012 hi  output  WIDTH  upper product half, registered.
REQ-013 lo  output  WIDTH  lower product half, registered.

Function
REQ-014 States IDLE, RUN, DONE; accept condition = state in {IDLE, DONE} and start=1 and flush=0.
REQ-015 On accept: latch op_a as multiplicand, load accumulator {1'b0, WIDTH'b0, op_b}, counter=0, next state RUN.
REQ-016 Each RUN cycle: if accumulator bit 0 = 1, add multiplicand to upper WIDTH+1 bits (carry kept); then logical shift accumulator right by 1; counter+1.
REQ-017 RUN lasts exactly WIDTH cycles; on the edge ending cycle WIDTH, hi/lo load accumulator bits [2W-1:W]/[W-1:0], state to DONE.
REQ-018 Latency: start accepted at edge k -> hi/lo valid after edge k+WIDTH; done=1 during cycle k+WIDTH.
REQ-019 DONE lasts one cycle, then IDLE unless a new accept occurs in DONE (then RUN).
REQ-020 busy = 1 exactly when state = RUN.
REQ-021 stall = busy and (start or hilo_rd); never asserted in IDLE or DONE.
REQ-022 start while RUN is ignored (not queued); the stall holds the instruction for re-issue.
REQ-023 flush in RUN: return to IDLE next edge, hi/lo unchanged, no done pulse.
REQ-024 flush in IDLE/DONE blocks acceptance of a same-cycle start; a DONE-cycle done pulse still occurs.
REQ-025 hi/lo change only per REQ-017 or reset; hi/lo readable combinationally from registers at all times.
REQ-026 Product exact for all unsigned inputs; carry bit prevents overflow loss (max 0xFFFFFFFF^2).

Reset
REQ-027 rst_n=0 asynchronously forces IDLE, counter=0, accumulator=0, hi=0, lo=0, busy=0, done=0, stall=0.
REQ-028 Reset mid-RUN aborts the multiply; first accept after rst_n rises behaves per REQ-015.

Structure
REQ-029 Shared package holds state enum, WIDTH default, funct codes MULTU=6'd25, MFHI=6'd16, MFLO=6'd18.
REQ-030 Single module; no sub-module required; the ALU control unit drives start/hilo_rd from the funct decode.

Verification
REQ-031 rst_n low, then start with op_a=3, op_b=5 -> done after 32 cycles, hi=0, lo=15, busy high exactly 32 cycles.
REQ-032 op_a=op_b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 op_a=0x80000000, op_b=2, then hilo_rd=1 on cycle 5 -> stall=1 cycles 5..31, hi=1, lo=0.
REQ-034 Start 7*9, flush at RUN cycle 10 -> IDLE next edge, no done, hi/lo keep prior values; start during RUN ignored.
REQ-035 Back-to-back: second start (2*4) held in DONE cycle of first (6*7) -> first lo=42, second lo=8 after 33 total cycles gap.
REQ-036 rst_n pulsed low mid-RUN -> all outputs 0 immediately, no done.
